// File: rtl/paper_fetch_sched.sv
// Framebuffer read scheduler: issues one AXI4 AR burst per fetch slot, walking
// a frame from its base address, gated by pixel-FIFO credit and by a limit on
// bursts accepted but not yet terminated by r_last.
module paper_fetch_sched #(
   parameter int unsigned AddrWidth      = 64,
   parameter int unsigned DataWidth      = 64,
   parameter int unsigned BurstLen       = 16,
   parameter int unsigned FifoDepth      = 512,
   parameter int unsigned MaxOutstanding = 4,
   parameter int unsigned CntWidth       = 24
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           en_i,
   input  logic [AddrWidth-1:0]           fb_base_i,
   input  logic [CntWidth-1:0]            frame_bursts_i,
   input  logic                           frame_start_i,
   input  logic [$clog2(FifoDepth+1)-1:0] fifo_fill_i,
   output logic                           ar_valid_o,
   input  logic                           ar_ready_i,
   output logic [AddrWidth-1:0]           ar_addr_o,
   output logic [7:0]                     ar_len_o,
   input  logic                           r_beat_i,
   input  logic                           r_last_i,
   output logic                           busy_o,
   output logic                           frame_done_o,
   output logic                           overrun_o
);

   localparam int unsigned BurstBytes = BurstLen * DataWidth / 8;
   localparam int unsigned FillW      = $clog2(FifoDepth + 1);
   // pend never legitimately exceeds FifoDepth; one spare bit keeps it clean
   localparam int unsigned PendW      = $clog2(FifoDepth + 1) + 1;
   localparam int unsigned OutW       = $clog2(MaxOutstanding + 1);
   localparam int unsigned MaxW0      = (FillW > PendW) ? FillW : PendW;
   localparam int unsigned MaxW       = (MaxW0 > 9) ? MaxW0 : 9;
   // fill + pend + BurstLen: two extra bits make the credit sum wrap-free
   localparam int unsigned SumW       = MaxW + 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARMED,
      ST_FETCH,
      ST_DRAIN
   } state_t;

   state_t                state_q;
   logic [CntWidth-1:0]   idx_q;
   logic [CntWidth-1:0]   bursts_q;
   logic [AddrWidth-1:0]  next_addr_q;
   logic [OutW-1:0]       out_q;
   logic [PendW-1:0]      pend_q;

   logic                  hs;
   logic                  start;
   logic                  out_dec;
   logic                  pend_dec;
   logic [OutW-1:0]       out_nxt;
   logic [PendW-1:0]      pend_nxt;
   logic [CntWidth-1:0]   idx_nxt;
   logic [CntWidth-1:0]   bursts_nxt;
   logic [AddrWidth-1:0]  addr_nxt;
   logic                  fetching;
   logic                  credit_ok;
   logic                  issue;
   logic                  last_hs;
   logic                  frame_complete;

   assign ar_len_o = 8'(BurstLen - 1);

   // Post-cycle counter values and the issue decision for the next AR slot
   always_comb begin
      hs         = ar_valid_o & ar_ready_i;
      start      = (state_q == ST_ARMED) & en_i & frame_start_i;
      // protocol errors saturate the counters at zero
      out_dec    = r_beat_i & r_last_i & (out_q != '0);
      pend_dec   = r_beat_i & (pend_q != '0);
      out_nxt    = out_q + OutW'(hs) - OutW'(out_dec);
      pend_nxt   = pend_q + (hs ? PendW'(BurstLen) : PendW'(0)) - PendW'(pend_dec);
      idx_nxt    = start ? '0 : idx_q + CntWidth'(hs);
      bursts_nxt = start ? frame_bursts_i : bursts_q;
      addr_nxt   = start ? fb_base_i
                 : (hs ? next_addr_q + AddrWidth'(BurstBytes) : next_addr_q);
      fetching   = start | ((state_q == ST_FETCH) & en_i);
      credit_ok  = (SumW'(fifo_fill_i) + SumW'(pend_nxt) + SumW'(BurstLen))
                   <= SumW'(FifoDepth);
      // a pending AR must complete before another can be offered
      issue      = fetching & (~ar_valid_o | ar_ready_i)
                 & (idx_nxt < bursts_nxt)
                 & (out_nxt < OutW'(MaxOutstanding))
                 & credit_ok;
      last_hs    = hs & (idx_nxt == bursts_q);
      frame_complete = (idx_q == bursts_q);
   end

   // Sequencer state, counters and registered outputs
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         bursts_q     <= '0;
         next_addr_q  <= '0;
         out_q        <= '0;
         pend_q       <= '0;
         ar_valid_o   <= 1'b0;
         ar_addr_o    <= '0;
         busy_o       <= 1'b0;
         frame_done_o <= 1'b0;
         overrun_o    <= 1'b0;
      end else begin
         out_q        <= out_nxt;
         pend_q       <= pend_nxt;
         idx_q        <= idx_nxt;
         bursts_q     <= bursts_nxt;
         next_addr_q  <= addr_nxt;
         frame_done_o <= 1'b0;

         if (issue) begin
            ar_valid_o <= 1'b1;
            ar_addr_o  <= addr_nxt;
         end else if (hs) begin
            ar_valid_o <= 1'b0;
         end

         if (frame_start_i && ((state_q == ST_FETCH) || (state_q == ST_DRAIN))) begin
            overrun_o <= 1'b1;
         end

         case (state_q)
            ST_IDLE: begin
               if (en_i) state_q <= ST_ARMED;
            end
            ST_ARMED: begin
               if (!en_i) begin
                  state_q <= ST_IDLE;
               end else if (frame_start_i) begin
                  state_q   <= ST_FETCH;
                  busy_o    <= 1'b1;
                  overrun_o <= 1'b0;
               end
            end
            ST_FETCH: begin
               if (last_hs || (!en_i && !ar_valid_o)) state_q <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (out_nxt == '0) begin
                  busy_o <= 1'b0;
                  if (frame_complete) begin
                     frame_done_o <= 1'b1;
                     state_q      <= en_i ? ST_ARMED : ST_IDLE;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // R beats with nothing pending are an upstream protocol violation
   a_beat_pending: assert property (@(posedge clk_i) disable iff (rst_i)
      !(r_beat_i && (pend_q == '0)))
      else $error("r_beat_i with no beats pending");

   a_last_outstanding: assert property (@(posedge clk_i) disable iff (rst_i)
      !(r_beat_i && r_last_i && (out_q == '0)))
      else $error("r_last_i with no burst outstanding");

endmodule

// File: tb/tb_paper_fetch_sched.sv
module tb_paper_fetch_sched;

   localparam int unsigned AW    = 64;
   localparam int unsigned BL    = 16;
   localparam int unsigned DEPTH = 512;
   localparam int unsigned MAXO  = 4;
   localparam int unsigned CW    = 24;
   localparam int unsigned FW    = 10;
   localparam longint unsigned BB = 128;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          en_i;
   logic [AW-1:0] fb_base_i;
   logic [CW-1:0] frame_bursts_i;
   logic          frame_start_i;
   logic [FW-1:0] fifo_fill_i;
   logic          ar_valid_o;
   logic          ar_ready_i;
   logic [AW-1:0] ar_addr_o;
   logic [7:0]    ar_len_o;
   logic          r_beat_i;
   logic          r_last_i;
   logic          busy_o;
   logic          frame_done_o;
   logic          overrun_o;

   paper_fetch_sched #(
      .AddrWidth(AW), .DataWidth(64), .BurstLen(BL), .FifoDepth(DEPTH),
      .MaxOutstanding(MAXO), .CntWidth(CW)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .fb_base_i(fb_base_i),
      .frame_bursts_i(frame_bursts_i), .frame_start_i(frame_start_i),
      .fifo_fill_i(fifo_fill_i), .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
      .ar_addr_o(ar_addr_o), .ar_len_o(ar_len_o), .r_beat_i(r_beat_i),
      .r_last_i(r_last_i), .busy_o(busy_o), .frame_done_o(frame_done_o),
      .overrun_o(overrun_o)
   );

   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad   = 0;

   // model: 0 idle, 1 armed, 2 fetch, 3 drain; q holds beats left per accepted burst
   int          m_mode;
   bit          m_valid, m_busy, m_done, m_over;
   logic [63:0] m_addr, m_base;
   int          m_issued, m_bursts;
   int          q[$];

   int          r_prob;
   int          cyc;
   logic [63:0] hs_addr[$];
   int          hs_cyc[$];
   int          last_rlast_cyc, done_cyc, done_cnt, rl_cnt, start_cyc;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_valid = 0; m_busy = 0; m_done = 0; m_over = 0;
      m_addr = '0; m_base = '0; m_issued = 0; m_bursts = 0;
      q.delete();
   endtask

   // one clock: drive R from the slave queue, advance the model, compare after the edge
   task automatic step();
      bit hs, beat, last, start, elig;
      int n_pend, old_mode;
      hs = m_valid && ar_ready_i;
      if (ar_valid_o && ar_ready_i) begin
         hs_addr.push_back(ar_addr_o);
         hs_cyc.push_back(cyc);
      end
      beat = 0; last = 0;
      if (q.size() > 0 && $urandom_range(0, 99) < r_prob) begin
         beat = 1;
         q[0] = q[0] - 1;
         if (q[0] == 0) begin
            last = 1;
            void'(q.pop_front());
         end
      end
      r_beat_i = beat;
      r_last_i = last;
      if (last) begin
         last_rlast_cyc = cyc;
         rl_cnt++;
      end
      if (hs) begin
         q.push_back(BL);
         m_issued++;
      end
      n_pend = 0;
      foreach (q[i]) n_pend += q[i];
      start = 0; m_done = 0; old_mode = m_mode;
      case (m_mode)
         0: if (en_i) m_mode = 1;
         1: begin
            if (!en_i) m_mode = 0;
            else if (frame_start_i) begin
               start = 1; m_mode = 2; m_base = fb_base_i;
               m_bursts = int'(frame_bursts_i); m_issued = 0; m_over = 0;
            end
         end
         2: begin
            if (frame_start_i) m_over = 1;
            if (hs && m_issued == m_bursts) m_mode = 3;
            else if (!en_i && !m_valid) m_mode = 3;
         end
         default: begin
            if (frame_start_i) m_over = 1;
            if (q.size() == 0) begin
               if (m_issued == m_bursts) begin
                  m_done = 1;
                  m_mode = en_i ? 1 : 0;
               end else m_mode = 0;
            end
         end
      endcase
      if (!(m_valid && !ar_ready_i)) begin
         elig = en_i && (start || old_mode == 2) && (m_issued < m_bursts)
                && (q.size() < MAXO) && (int'(fifo_fill_i) + n_pend + BL <= DEPTH);
         m_valid = elig;
         if (elig) m_addr = m_base + 64'(m_issued) * BB;
      end
      m_busy = (m_mode == 2) || (m_mode == 3);
      @(posedge clk_i);
      #1;
      cyc++;
      check("ar_valid", ar_valid_o, m_valid);
      if (m_valid) check("ar_addr", ar_addr_o, m_addr);
      check("ar_len", ar_len_o, 64'(BL - 1));
      check("busy", busy_o, m_busy);
      check("frame_done", frame_done_o, m_done);
      check("overrun", overrun_o, m_over);
      if (frame_done_o) begin
         done_cyc = cyc;
         done_cnt++;
      end
   endtask

   task automatic run_until_done(input string name, input int budget);
      int n = 0;
      while (done_cnt == 0 && n < budget) begin
         step();
         n++;
      end
      check(name, 64'(done_cnt != 0), 64'd1);
   endtask

   task automatic run_until_rlast(input string name, input int target, input int budget);
      int n = 0;
      while (rl_cnt < target && n < budget) begin
         step();
         n++;
      end
      check(name, 64'(rl_cnt), 64'(target));
   endtask

   task automatic begin_frame(input logic [63:0] base, input int bursts);
      fb_base_i = base;
      frame_bursts_i = CW'(bursts);
      frame_start_i = 1;
      hs_addr.delete(); hs_cyc.delete();
      done_cnt = 0; rl_cnt = 0;
      start_cyc = cyc;
      step();
      frame_start_i = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i = 1; en_i = 0; fb_base_i = '0; frame_bursts_i = CW'(1);
      frame_start_i = 0; fifo_fill_i = '0; ar_ready_i = 0;
      r_beat_i = 0; r_last_i = 0; r_prob = 0; cyc = 0;
      last_rlast_cyc = -1; done_cyc = -1; done_cnt = 0; rl_cnt = 0; start_cyc = 0;
      model_reset();
      #3;
      check("rst_valid", ar_valid_o, 0);
      check("rst_addr", ar_addr_o, 0);
      check("rst_len", ar_len_o, 64'h0f);
      check("rst_busy", busy_o, 0);
      check("rst_done", frame_done_o, 0);
      check("rst_overrun", overrun_o, 0);
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 0;

      // basic three-burst frame
      en_i = 1; ar_ready_i = 1; fifo_fill_i = '0;
      step();
      begin_frame(64'h8000_0000, 3);
      check("t1_first_valid", ar_valid_o, 1);
      repeat (3) step();
      check("t1_ar_count", 64'(hs_addr.size()), 3);
      if (hs_addr.size() >= 3) begin
         check("t1_addr0", hs_addr[0], 64'h8000_0000);
         check("t1_addr1", hs_addr[1], 64'h8000_0080);
         check("t1_addr2", hs_addr[2], 64'h8000_0100);
         check("t1_cyc0", 64'(hs_cyc[0]), 64'(start_cyc + 1));
         check("t1_cyc2", 64'(hs_cyc[2]), 64'(start_cyc + 3));
      end
      r_prob = 100;
      run_until_done("t1_done_timeout", 200);
      check("t1_done_after_rlast", 64'(done_cyc), 64'(last_rlast_cyc + 1));
      check("t1_rlasts", 64'(rl_cnt), 3);

      // credit gating on FIFO fill
      fifo_fill_i = FW'(500);
      begin_frame(64'h0000_1000, 2);
      check("t2_blocked0", ar_valid_o, 0);
      repeat (3) step();
      check("t2_blocked3", ar_valid_o, 0);
      fifo_fill_i = FW'(496);
      step();
      check("t2_open", ar_valid_o, 1);
      check("t2_addr", ar_addr_o, 64'h0000_1000);
      fifo_fill_i = '0;
      run_until_done("t2_done_timeout", 300);

      // outstanding-burst limit
      r_prob = 0;
      begin_frame(64'h0010_0000, 10);
      repeat (12) step();
      check("t3_limit", 64'(hs_addr.size()), 4);
      r_prob = 100;
      run_until_rlast("t3_first_rlast", 1, 60);
      r_prob = 0;
      step();
      check("t3_fifth", 64'(hs_addr.size()), 5);
      if (hs_addr.size() >= 5) check("t3_addr4", hs_addr[4], 64'h0010_0200);
      r_prob = 100;
      run_until_done("t3_done_timeout", 600);

      // AR held stable under backpressure
      ar_ready_i = 0;
      begin_frame(64'h0000_2000, 1);
      for (int i = 0; i < 5; i++) begin
         check("t4_hold_valid", ar_valid_o, 1);
         check("t4_hold_addr", ar_addr_o, 64'h0000_2000);
         step();
      end
      check("t4_no_hs_yet", 64'(hs_addr.size()), 0);
      ar_ready_i = 1;
      step();
      check("t4_hs_cycle", 64'(hs_cyc.size() > 0 ? hs_cyc[0] : -1), 64'(start_cyc + 6));
      run_until_done("t4_done_timeout", 100);

      // frame start during fetch only flags overrun
      begin_frame(64'h3000_0000, 3);
      frame_start_i = 1;
      step();
      frame_start_i = 0;
      check("t5_overrun_set", overrun_o, 1);
      run_until_done("t5_done_timeout", 200);
      check("t5_addr_count", 64'(hs_addr.size()), 3);
      if (hs_addr.size() >= 3) check("t5_addr2", hs_addr[2], 64'h3000_0100);
      check("t5_overrun_sticky", overrun_o, 1);

      // abort with two bursts outstanding
      r_prob = 0;
      begin_frame(64'h0000_4000, 6);
      check("t6_overrun_clear", overrun_o, 0);
      step();
      en_i = 0;
      step();
      repeat (4) step();
      check("t6_two_ars", 64'(hs_addr.size()), 2);
      check("t6_busy", busy_o, 1);
      r_prob = 100;
      run_until_rlast("t6_rlasts", 2, 100);
      check("t6_idle", busy_o, 0);
      check("t6_no_done", 64'(done_cnt), 0);

      // asynchronous reset mid-burst
      en_i = 1;
      step();
      r_prob = 50;
      begin_frame(64'h0000_8000, 4);
      repeat (2) step();
      rst_i = 1;
      #1;
      check("arst_valid", ar_valid_o, 0);
      check("arst_addr", ar_addr_o, 0);
      check("arst_busy", busy_o, 0);
      check("arst_done", frame_done_o, 0);
      check("arst_overrun", overrun_o, 0);
      r_beat_i = 0; r_last_i = 0;
      @(posedge clk_i);
      #1;
      rst_i = 0;
      model_reset();

      // randomized traffic
      for (int c = 0; c < 4000; c++) begin
         if (c % 200 == 0) r_prob = $urandom_range(20, 100);
         ar_ready_i = ($urandom_range(0, 99) < 70);
         fifo_fill_i = ($urandom_range(0, 3) == 0) ? FW'($urandom_range(440, 512))
                                                   : FW'($urandom_range(0, 200));
         if ($urandom_range(0, 199) == 0) en_i = ~en_i;
         else if (c < 10) en_i = 1;
         if ($urandom_range(0, 9) == 0) begin
            if ($urandom_range(0, 3) == 0)
               fb_base_i = 64'hFFFF_FFFF_FFFF_FF80 - 64'(128 * $urandom_range(0, 3));
            else
               fb_base_i = {$urandom, $urandom} & ~64'h7F;
            frame_bursts_i = CW'($urandom_range(1, 8));
         end
         frame_start_i = ($urandom_range(0, 99) < 4);
         step();
      end
      frame_start_i = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
